// File: rtl/mc_controller.sv
// Multicycle main control FSM: fetch/decode/execute/writeback/branch sequencing for the 8-bit core.
// Optional feature macro: STEP_EN (adds a single-step debug input that gates each fetch).
module mc_controller #(
  parameter int WAIT_MAX = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
`ifdef STEP_EN
  input  logic             step,
`endif
  input  logic             imem_ack,
  input  logic [7:0]       instr,
  input  logic             zero,
  output logic             imem_req,
  output logic             irwrite,
  output logic [1:0]       aluop,
  output logic [1:0]       funct,
  output logic             regwrite,
  output logic             pcwrite,
  output logic             pcsrc,
  output logic             fault,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_BRANCH = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t           state_reg, state_next;
  logic [1:0]       op_reg, op_next;
  logic [1:0]       funct_reg, funct_next;
  logic [7:0]       wait_reg, wait_next;
  logic [CNT_W-1:0] retired_reg, retired_next;
  logic             fault_reg, fault_next;
  logic             go;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^instr[3:0];

`ifdef STEP_EN
  // One pending permit; consumed by the fetch it allows, extra pulses are dropped.
  logic permit_reg, permit_next;
  assign go = permit_reg;

  always_comb begin
    permit_next = permit_reg;
    if (state_reg == S_FETCH && permit_reg && imem_ack)
      permit_next = 1'b0;
    else if (step)
      permit_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) permit_reg <= 1'b0;
    else       permit_reg <= permit_next;
  end
`else
  assign go = 1'b1;
`endif

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    funct_next   = funct_reg;
    wait_next    = wait_reg;
    retired_next = retired_reg;
    fault_next   = fault_reg;
    imem_req     = 1'b0;
    irwrite      = 1'b0;
    aluop        = 2'b00;
    regwrite     = 1'b0;
    pcwrite      = 1'b0;
    pcsrc        = 1'b0;
    case (state_reg)
      S_FETCH: begin
        imem_req = go;
        if (go) begin
          if (imem_ack) begin
            irwrite    = 1'b1;
            op_next    = instr[7:6];
            funct_next = instr[5:4];
            wait_next  = 8'd0;
            state_next = S_DECODE;
          end else begin
            wait_next = wait_reg + 8'd1;
            if (wait_reg + 8'd1 == WAIT_LIM) begin
              state_next = S_FAULT;
              fault_next = 1'b1;
            end
          end
        end
      end
      S_DECODE: begin
        aluop      = op_reg;
        state_next = (op_reg == 2'b11) ? S_BRANCH : S_EXEC;
      end
      S_EXEC: begin
        aluop      = op_reg;
        state_next = S_WB;
      end
      S_WB: begin
        aluop        = op_reg;
        regwrite     = 1'b1;
        pcwrite      = 1'b1;
        retired_next = retired_reg + 1'b1;
        state_next   = S_FETCH;
      end
      S_BRANCH: begin
        // funct[1] marks unconditional branches; others depend on zero.
        aluop        = 2'b11;
        pcwrite      = 1'b1;
        pcsrc        = funct_reg[1] | zero;
        retired_next = retired_reg + 1'b1;
        state_next   = S_FETCH;
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FETCH;
    endcase
    if (reset) begin
      imem_req = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      pcwrite  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      op_reg      <= 2'b00;
      funct_reg   <= 2'b00;
      wait_reg    <= 8'd0;
      retired_reg <= '0;
      fault_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      funct_reg   <= funct_next;
      wait_reg    <= wait_next;
      retired_reg <= retired_next;
      fault_reg   <= fault_next;
    end
  end

  assign funct   = funct_reg;
  assign fault   = fault_reg;
  assign retired = retired_reg;
  assign state   = state_reg;

endmodule
